// File: rtl/data_ser_tx.sv
// data_ser_tx: 8-lane SDR serializer with ADC-style frame and bitslip training.
// Each word is shifted out MSB first, one bit per lane per clock; a training
// burst of TRAIN_PATTERN words is sent after reset and on request.
module data_ser_tx #(
    parameter int unsigned       LANES         = 8,
    parameter int unsigned       WORD          = 8,
    parameter logic [WORD-1:0]   TRAIN_PATTERN = 8'hF0,
    parameter int unsigned       TRAIN_WORDS   = 16
) (
    input  logic                  clk0,
    input  logic                  rst_n,
    input  logic                  train_req,
    input  logic [LANES*WORD-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [LANES-1:0]      tx_data,
    output logic                  tx_frame,
    output logic                  training,
    output logic                  underflow
);

    localparam int unsigned CW = $clog2(TRAIN_WORDS + 1);
    localparam int unsigned BW = $clog2(WORD);

    localparam logic [BW-1:0] LAST_BIT = BW'(WORD - 1);
    localparam logic [BW-1:0] HALF     = BW'(WORD / 2);
    localparam logic [CW-1:0] TW       = CW'(TRAIN_WORDS);

    typedef enum logic {
        ST_TRAIN,
        ST_DATA
    } state_t;

    state_t                     state, state_n;
    logic [CW-1:0]              train_cnt, train_cnt_n, cnt_base;
    logic [BW-1:0]              bit_cnt, bit_cnt_n;
    logic [LANES-1:0][WORD-1:0] sr, sr_n;
    logic [LANES-1:0]           tx_n;
    logic                       train_pending, pend_n;
    logic                       training_n, underflow_n;
    logic                       load, req;

    assign load    = (bit_cnt == LAST_BIT);
    assign req     = train_pending | train_req;
    assign s_ready = load && (state == ST_DATA) && !req && rst_n;

    // Next-state: word selection on load cycles, shifting on all others.
    // A pending request re-enters training by reloading the counter and
    // consuming the first training word in the same load cycle.
    always_comb begin
        state_n     = state;
        train_cnt_n = train_cnt;
        cnt_base    = train_cnt;
        pend_n      = req;
        bit_cnt_n   = bit_cnt + 1'b1;
        training_n  = training;
        underflow_n = 1'b0;
        for (int unsigned i = 0; i < LANES; i++) begin
            sr_n[i] = {sr[i][WORD-2:0], 1'b0};
        end

        if (load) begin
            bit_cnt_n = '0;
            pend_n    = 1'b0;
            if (req || state == ST_TRAIN) begin
                cnt_base    = req ? TW : train_cnt;
                train_cnt_n = cnt_base - 1'b1;
                state_n     = (train_cnt_n == '0) ? ST_DATA : ST_TRAIN;
                sr_n        = {LANES{TRAIN_PATTERN}};
                training_n  = 1'b1;
            end else begin
                training_n = 1'b0;
                if (s_valid) begin
                    sr_n = s_data;
                end else begin
                    sr_n        = '0;
                    underflow_n = 1'b1;
                end
            end
        end

        for (int unsigned i = 0; i < LANES; i++) begin
            tx_n[i] = sr_n[i][WORD-1];
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk0) begin
        if (!rst_n) begin
            state         <= ST_TRAIN;
            train_cnt     <= TW;
            bit_cnt       <= LAST_BIT;
            sr            <= '0;
            train_pending <= 1'b0;
            tx_data       <= '0;
            tx_frame      <= 1'b0;
            training      <= 1'b0;
            underflow     <= 1'b0;
        end else begin
            state         <= state_n;
            train_cnt     <= train_cnt_n;
            bit_cnt       <= bit_cnt_n;
            sr            <= sr_n;
            train_pending <= pend_n;
            tx_data       <= tx_n;
            tx_frame      <= (bit_cnt_n < HALF);
            training      <= training_n;
            underflow     <= underflow_n;
        end
    end

endmodule
